alu_pipe: RTL and testbench

Parametrised, registered successor to the team's 8-bit combinational ALU. Adds:
- generic operand width;
- 16 operations, including carry-chained add/subtract, shifts/rotate and a multi-cycle multiply;
- an NZCV flag set;
- a persistent carry flag;
- valid/ready handshakes on both sides.

It sits between an instruction/operand source and a result consumer in datapath designs. It is the reusable ALU core for later blocks, such as a small CPU.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_mul_seq.sv | 52 +++++
 rtl/alu_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_alu_pipe.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcodes, flag bundle and FSM states.
// Imported by alu_pipe and alu_mul_seq.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOR  = 4'd5,
    OP_NAND = 4'd6,
    OP_XNOR = 4'd7,
    OP_ADC  = 4'd8,
    OP_SBB  = 4'd9,
    OP_CMP  = 4'd10,
    OP_SHL  = 4'd11,
    OP_SHR  = 4'd12,
    OP_SRA  = 4'd13,
    OP_ROL  = 4'd14,
    OP_MUL  = 4'd15
  } alu_op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic {
    ST_IDLE,
    ST_MUL_BUSY
  } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier, one partial product per clock.
// done is high while product holds the finished value.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_p;
  logic [CW-1:0]      r_cnt;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_step;

  // Upper half accumulates, lower half shifts the multiplier out
  assign w_addend = r_p[0] ? r_mcand : '0;
  assign w_sum    = {1'b0, r_p[2*WIDTH-1:WIDTH]}
                  + {1'b0, w_addend};
  assign w_step   = {w_sum, r_p[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
    end else if (start) begin
      r_mcand <= a;
      r_p     <= {{WIDTH{1'b0}}, b};
      r_cnt   <= CW'(WIDTH);
    end else if (r_cnt != '0) begin
      r_p     <= w_step;
      r_cnt   <= r_cnt - CW'(1);
    end
  end

  // Last step is forwarded so the result lands WIDTH cycles after start
  assign done    = (r_cnt <= CW'(1));
  assign product = (r_cnt == CW'(1)) ? w_step : r_p;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with NZCV flags, persistent carry and a multi-cycle MUL.
// valid/ready on both sides; single-cycle ops run at full rate.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  alu_state_t       r_state;
  logic             r_cy;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  alu_flags_t       r_flags;

  alu_op_t          w_op;
  logic             w_out_free;
  logic             w_in_ready;
  logic             w_acc;
  logic             w_single_load;
  logic             w_mul_start;
  logic             w_mul_done;
  logic             w_mul_load;
  logic [2*WIDTH-1:0] w_prod;

  logic [SHW-1:0]   w_sh;
  logic             w_cin;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic             w_add_v;
  logic             w_sub_v;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_shr;
  logic signed [WIDTH:0] w_sra_in;
  logic [WIDTH:0]   w_sra;
  logic [WIDTH-1:0] w_rol;

  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_nz_src;
  logic             w_c;
  logic             w_v;
  alu_flags_t       w_flags;
  alu_flags_t       w_mul_flags;

  assign w_op = alu_op_t'(op);

  assign w_out_free    = !r_out_valid || out_ready;
  assign w_in_ready    = (r_state == ST_IDLE) && w_out_free;
  assign w_acc         = in_valid && w_in_ready;
  assign w_mul_start   = w_acc && (w_op == OP_MUL);
  assign w_single_load = w_acc && (w_op != OP_MUL);
  assign w_mul_load    = (r_state == ST_MUL_BUSY)
                      && w_mul_done && w_out_free;

  // Carry-in only participates for the chained forms
  assign w_cin = r_cy && ((w_op == OP_ADC) || (w_op == OP_SBB));

  assign w_add = {1'b0, a} + {1'b0, b}
               + {{WIDTH{1'b0}}, w_cin};
  assign w_sub = {1'b0, a} - {1'b0, b}
               - {{WIDTH{1'b0}}, w_cin};

  assign w_add_v = (a[WIDTH-1] == b[WIDTH-1])
                && (w_add[WIDTH-1] != a[WIDTH-1]);
  assign w_sub_v = (a[WIDTH-1] != b[WIDTH-1])
                && (w_sub[WIDTH-1] != a[WIDTH-1]);

  // Extra guard bit catches the last bit shifted out
  assign w_sh     = b[SHW-1:0];
  assign w_shl    = {1'b0, a} << w_sh;
  assign w_shr    = {a, 1'b0} >> w_sh;
  assign w_sra_in = {a, 1'b0};
  assign w_sra    = w_sra_in >>> w_sh;

  always_comb begin
    w_rol = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_rol[i] = a[SHW'(i) - w_sh];
    end
  end

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    unique case (w_op)
      OP_ADD, OP_ADC: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = w_add_v;
      end
      OP_SUB, OP_SBB: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = w_sub[WIDTH];
        w_v   = w_sub_v;
      end
      OP_CMP: begin
        w_res = a;
        w_c   = w_sub[WIDTH];
        w_v   = w_sub_v;
      end
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_NOR:  w_res = ~(a | b);
      OP_NAND: w_res = ~(a & b);
      OP_XNOR: w_res = ~(a ^ b);
      OP_SHL: begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      OP_SRA: begin
        w_res = w_sra[WIDTH:1];
        w_c   = w_sra[0];
      end
      OP_ROL: begin
        w_res = w_rol;
        w_c   = (w_sh != '0) && w_rol[0];
      end
      OP_MUL: w_res = '0;
      default: w_res = '0;
    endcase
  end

  // CMP reports N/Z of the difference while passing A through
  assign w_nz_src  = (w_op == OP_CMP) ? w_sub[WIDTH-1:0] : w_res;
  assign w_flags.n = w_nz_src[WIDTH-1];
  assign w_flags.z = (w_nz_src == '0);
  assign w_flags.c = w_c;
  assign w_flags.v = w_v;

  assign w_mul_flags.n = w_prod[WIDTH-1];
  assign w_mul_flags.z = (w_prod == '0);
  assign w_mul_flags.c = |w_prod[2*WIDTH-1:WIDTH];
  assign w_mul_flags.v = |w_prod[2*WIDTH-1:WIDTH];

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (w_mul_start),
    .a       (a),
    .b       (b),
    .done    (w_mul_done),
    .product (w_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cy        <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_flags     <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE:
          if (w_mul_start) r_state <= ST_MUL_BUSY;
        ST_MUL_BUSY:
          if (w_mul_load) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      if (w_single_load) begin
        r_result    <= w_res;
        r_result_hi <= '0;
        r_flags     <= w_flags;
        r_cy        <= w_flags.c;
        r_out_valid <= 1'b1;
      end else if (w_mul_load) begin
        r_result    <= w_prod[WIDTH-1:0];
        r_result_hi <= w_prod[2*WIDTH-1:WIDTH];
        r_flags     <= w_mul_flags;
        r_cy        <= w_mul_flags.c;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign flag_n    = r_flags.n;
  assign flag_z    = r_flags.z;
  assign flag_c    = r_flags.c;
  assign flag_v    = r_flags.v;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=8.
// Directed cases plus a randomised mix checked against an integer model.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         flag_n;
  logic         flag_z;
  logic         flag_c;
  logic         flag_v;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [3:0]   f;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  logic m_cy = 1'b0;
  logic seen;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] r,
                              input logic [7:0] h,
                              input logic [3:0] f);
    exp_t e;
    e.res = r;
    e.hi  = h;
    e.f   = f;
    return e;
  endfunction

  function automatic exp_t model(input logic [3:0] o,
                                 input logic [7:0] x,
                                 input logic [7:0] y,
                                 input logic cy);
    int ua, ub, sa, sb_, ci, t, s, sh;
    logic [7:0] r, h, q, x2;
    logic n, z, c, v;
    ua = x; ub = y; ci = cy;
    sa = $signed(x); sb_ = $signed(y);
    t = 0; s = 0; r = 0; h = 0; c = 0; v = 0;
    sh = y[2:0];
    x2 = x;
    case (o)
      4'd0, 4'd8: begin
        if (o == 4'd0) ci = 0;
        t = ua + ub + ci; s = sa + sb_ + ci;
        r = t[7:0]; c = (t > 255);
        v = (s > 127) || (s < -128);
      end
      4'd1, 4'd9, 4'd10: begin
        if (o != 4'd9) ci = 0;
        t = ua - ub - ci; s = sa - sb_ - ci;
        r = t[7:0]; c = (ua < ub + ci);
        v = (s > 127) || (s < -128);
      end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = ~(x | y);
      4'd6: r = ~(x & y);
      4'd7: r = ~(x ^ y);
      4'd11: begin
        for (int i = 0; i < sh; i++) begin
          c = x2[7]; x2 = {x2[6:0], 1'b0};
        end
        r = x2;
      end
      4'd12: begin
        for (int i = 0; i < sh; i++) begin
          c = x2[0]; x2 = {1'b0, x2[7:1]};
        end
        r = x2;
      end
      4'd13: begin
        for (int i = 0; i < sh; i++) begin
          c = x2[0]; x2 = {x2[7], x2[7:1]};
        end
        r = x2;
      end
      4'd14: begin
        for (int i = 0; i < sh; i++) x2 = {x2[6:0], x2[7]};
        r = x2; c = (sh != 0) && x2[0];
      end
      default: begin
        t = ua * ub;
        r = t[7:0]; h = t[15:8];
        c = (h != 0); v = c;
      end
    endcase
    q = (o == 4'd10) ? t[7:0] : r;
    n = q[7];
    z = (o == 4'd15) ? (t == 0) : (q == 0);
    if (o == 4'd10) r = x;
    return mk(r, h, {n, z, c, v});
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("result", result, mon_e.res);
        check("result_hi", result_hi, mon_e.hi);
        check("flags", {flag_n, flag_z, flag_c, flag_v}, mon_e.f);
      end
    end
  end

  task automatic send(input logic [3:0] o,
                      input logic [7:0] x,
                      input logic [7:0] y,
                      input logic push,
                      input exp_t e);
    bit ok;
    ok = 0;
    in_valid = 1'b1; op = o; a = x; b = y;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    check("accept_timeout", ok, 1);
    if (push) begin
      sb.push_back(e);
      m_cy = e.f[1];
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic sendm(input logic [3:0] o,
                       input logic [7:0] x,
                       input logic [7:0] y);
    send(o, x, y, 1'b1, model(o, x, y, m_cy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = '0;
    a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_result_hi", result_hi, 0);
    check("rst_flags", {flag_n, flag_z, flag_c, flag_v}, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    send(OP_ADD, 8'hFF, 8'h01, 1'b1, mk(8'h00, 8'h00, 4'b0110));
    check("add_latency", out_valid, 1);
    send(OP_SUB, 8'h80, 8'h01, 1'b1, mk(8'h7F, 8'h00, 4'b0001));
    send(OP_CMP, 8'h01, 8'h02, 1'b1, mk(8'h01, 8'h00, 4'b1010));

    send(OP_ADD, 8'hFF, 8'h01, 1'b1, mk(8'h00, 8'h00, 4'b0110));
    send(OP_ADC, 8'h00, 8'h00, 1'b1, mk(8'h01, 8'h00, 4'b0000));
    send(OP_ADD, 8'hFF, 8'h01, 1'b1, mk(8'h00, 8'h00, 4'b0110));
    send(OP_SBB, 8'h00, 8'h00, 1'b1, mk(8'hFF, 8'h00, 4'b1010));

    send(OP_SHL, 8'h81, 8'h01, 1'b1, mk(8'h02, 8'h00, 4'b0010));
    send(OP_SRA, 8'h80, 8'h03, 1'b1, mk(8'hF0, 8'h00, 4'b1000));

    send(OP_MUL, 8'hFF, 8'hFF, 1'b1, mk(8'h01, 8'hFE, 4'b0011));
    check("mul_ready_0", in_ready, 0);
    check("mul_valid_0", out_valid, 0);
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #1;
      check("mul_ready_busy", in_ready, 0);
      check("mul_valid_busy", out_valid, 0);
    end
    @(posedge clk); #1;
    check("mul_valid_8", out_valid, 1);

    @(posedge clk); #1;
    out_ready = 1'b0;
    send(OP_ADD, 8'h03, 8'h04, 1'b1, mk(8'h07, 8'h00, 4'b0000));
    in_valid = 1'b1; op = OP_ADD; a = 8'h10; b = 8'h20;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_hold", result, 8'h07);
      check("bp_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_accept", in_ready, 1);
    sb.push_back(mk(8'h30, 8'h00, 4'b0000));
    m_cy = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_new_valid", out_valid, 1);
    check("bp_new_res", result, 8'h30);

    send(OP_ADD, 8'hF0, 8'h20, 1'b1, mk(8'h10, 8'h00, 4'b0010));
    send(OP_MUL, 8'h05, 8'h07, 1'b0, mk(8'h00, 8'h00, 4'b0000));
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_result", result, 0);
    check("mrst_hi", result_hi, 0);
    check("mrst_flags", {flag_n, flag_z, flag_c, flag_v}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_cy = 1'b0;
    #1;
    check("mrst_in_ready", in_ready, 1);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("mrst_no_out", seen, 0);
    @(posedge clk); #1;
    send(OP_ADC, 8'h01, 8'h01, 1'b1, mk(8'h02, 8'h00, 4'b0000));

    for (int it = 0; it < 40; it++) begin
      out_ready = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      sendm(4'($urandom_range(0, 15)),
            8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)));
    end

    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    check("drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
